// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive safety checker for a two-way traffic light controller. Decodes the
// six lamp drives into a phase each clock, tracks how long the phase has been
// held, and checks encoding, mutual exclusion, phase ordering and dwell
// limits. The first fault seen is latched together with its code until a
// fault_clear or reset.

module traffic_light_monitor #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_PHASE = 20,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fault_clear,
    input  logic             rn,
    input  logic             yn,
    input  logic             gn,
    input  logic             re,
    input  logic             ye,
    input  logic             ge,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic [7:0]       cycle_count,
    output logic             fault,
    output logic [2:0]       fault_code
);

    // Phase encoding as presented on the phase output.
    localparam logic [2:0] PH_UNKNOWN = 3'd0;
    localparam logic [2:0] PH_NS_G    = 3'd1;
    localparam logic [2:0] PH_NS_Y    = 3'd2;
    localparam logic [2:0] PH_ALL_RED = 3'd3;
    localparam logic [2:0] PH_EW_G    = 3'd4;
    localparam logic [2:0] PH_EW_Y    = 3'd5;
    localparam logic [2:0] PH_INVALID = 3'd7;

    // Fault codes, lower value means higher priority.
    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_CONFLICT    = 3'd1;
    localparam logic [2:0] FC_ENCODING    = 3'd2;
    localparam logic [2:0] FC_SEQUENCE    = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN = 3'd4;
    localparam logic [2:0] FC_STUCK       = 3'd5;

    localparam logic [CNT_W-1:0] DWELL_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_PHASE_C = CNT_W'(MAX_PHASE);
    localparam bit               STUCK_EN    = (MAX_PHASE != 0);

    // SYNC: waiting for the first legal phase, no ordering knowledge yet.
    // RUN: ordering and short-green checks are active.
    typedef enum logic {
        MODE_SYNC = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    // Direction of the most recent green, used to enforce alternation
    // when leaving ALL_RED.
    typedef enum logic [1:0] {
        LG_NONE = 2'd0,
        LG_NS   = 2'd1,
        LG_EW   = 2'd2
    } green_t;

    // Registered state
    logic [2:0]       phase_reg,       phase_next;
    logic [CNT_W-1:0] dwell_reg,       dwell_next;
    logic [7:0]       cycle_count_reg, cycle_count_next;
    logic             fault_reg,       fault_next;
    logic [2:0]       fault_code_reg,  fault_code_next;
    mode_t            mode_reg,        mode_next;
    green_t           last_green_reg,  last_green_next;

    // Combinational decode of the current lamp sample
    logic       ns_one_hot;
    logic       ew_one_hot;
    logic       conflict;
    logic       encoding_bad;
    logic [2:0] sample_phase;
    logic       phase_changed;
    logic       legal_step;
    logic       leaving_green;
    logic [2:0] new_code;

    // Lamp group legality: exactly one lamp per direction, no simultaneous
    // go/caution lamps on both directions.
    always_comb begin
        ns_one_hot   = (rn ^ yn ^ gn) & ~(rn & yn & gn);
        ew_one_hot   = (re ^ ye ^ ge) & ~(re & ye & ge);
        conflict     = (gn | yn) & (ge | ye);
        encoding_bad = ~ns_one_hot | ~ew_one_hot;
    end

    // Map a legal lamp pattern onto its phase; anything else is INVALID.
    always_comb begin
        sample_phase = PH_INVALID;
        if (!conflict && !encoding_bad) begin
            if (gn && re) begin
                sample_phase = PH_NS_G;
            end else if (yn && re) begin
                sample_phase = PH_NS_Y;
            end else if (rn && re) begin
                sample_phase = PH_ALL_RED;
            end else if (rn && ge) begin
                sample_phase = PH_EW_G;
            end else if (rn && ye) begin
                sample_phase = PH_EW_Y;
            end
        end
    end

    // Transition legality against the registered phase. Leaving ALL_RED
    // must select the direction that did not have the previous green; with
    // no green seen yet since sync either direction is acceptable.
    always_comb begin
        phase_changed = (sample_phase != phase_reg);
        legal_step    = 1'b0;
        case (phase_reg)
            PH_NS_G:    legal_step = (sample_phase == PH_NS_Y);
            PH_NS_Y:    legal_step = (sample_phase == PH_ALL_RED);
            PH_EW_G:    legal_step = (sample_phase == PH_EW_Y);
            PH_EW_Y:    legal_step = (sample_phase == PH_ALL_RED);
            PH_ALL_RED: legal_step = ((sample_phase == PH_EW_G) && (last_green_reg != LG_EW))
                                  || ((sample_phase == PH_NS_G) && (last_green_reg != LG_NS));
            default:    legal_step = 1'b0;
        endcase
        leaving_green = phase_changed
                     && ((phase_reg == PH_NS_G) || (phase_reg == PH_EW_G));
    end

    // Prioritised fault selection for this sample; only the top one counts.
    always_comb begin
        new_code = FC_NONE;
        if (conflict) begin
            new_code = FC_CONFLICT;
        end else if (encoding_bad) begin
            new_code = FC_ENCODING;
        end else if ((mode_reg == MODE_RUN) && phase_changed && !legal_step) begin
            new_code = FC_SEQUENCE;
        end else if ((mode_reg == MODE_RUN) && leaving_green && (dwell_reg < MIN_GREEN_C)) begin
            new_code = FC_SHORT_GREEN;
        end else if (STUCK_EN && !phase_changed && (dwell_reg == MAX_PHASE_C)) begin
            new_code = FC_STUCK;
        end
    end

    // Next-state logic: phase/dwell always follow the lamps, checks and the
    // cycle counter only run while no fault is latched.
    always_comb begin
        phase_next       = sample_phase;
        dwell_next       = dwell_reg;
        cycle_count_next = cycle_count_reg;
        fault_next       = fault_reg;
        fault_code_next  = fault_code_reg;
        mode_next        = mode_reg;
        last_green_next  = last_green_reg;

        if (phase_changed) begin
            dwell_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (dwell_reg != DWELL_MAX) begin
            dwell_next = dwell_reg + 1'b1;
        end

        if (sample_phase == PH_NS_G) begin
            last_green_next = LG_NS;
        end else if (sample_phase == PH_EW_G) begin
            last_green_next = LG_EW;
        end

        if (!fault_reg) begin
            if (new_code != FC_NONE) begin
                fault_next      = 1'b1;
                fault_code_next = new_code;
            end else if (mode_reg == MODE_SYNC) begin
                // First legal phase after sync is taken as-is.
                mode_next = MODE_RUN;
            end else if ((phase_reg == PH_ALL_RED) && (sample_phase == PH_NS_G)) begin
                cycle_count_next = cycle_count_reg + 8'd1;
            end
        end
    end

    // State register; reset beats fault_clear, and a clear discards the
    // sample taken on the same edge while keeping the cycle count.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_reg       <= PH_UNKNOWN;
            dwell_reg       <= '0;
            cycle_count_reg <= 8'd0;
            fault_reg       <= 1'b0;
            fault_code_reg  <= FC_NONE;
            mode_reg        <= MODE_SYNC;
            last_green_reg  <= LG_NONE;
        end else if (fault_clear) begin
            phase_reg       <= PH_UNKNOWN;
            dwell_reg       <= '0;
            fault_reg       <= 1'b0;
            fault_code_reg  <= FC_NONE;
            mode_reg        <= MODE_SYNC;
            last_green_reg  <= LG_NONE;
        end else begin
            phase_reg       <= phase_next;
            dwell_reg       <= dwell_next;
            cycle_count_reg <= cycle_count_next;
            fault_reg       <= fault_next;
            fault_code_reg  <= fault_code_next;
            mode_reg        <= mode_next;
            last_green_reg  <= last_green_next;
        end
    end

    assign phase       = phase_reg;
    assign dwell       = dwell_reg;
    assign cycle_count = cycle_count_reg;
    assign fault       = fault_reg;
    assign fault_code  = fault_code_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor: legal cycle, each fault code,
// fault_clear behaviour and reset dominance, with hand-computed expectations.

module tb_traffic_light_monitor;

    // Lamp patterns ordered {rn, yn, gn, re, ye, ge}
    localparam logic [5:0] L_NS_G    = 6'b001_100;
    localparam logic [5:0] L_NS_Y    = 6'b010_100;
    localparam logic [5:0] L_ALL_RED = 6'b100_100;
    localparam logic [5:0] L_EW_G    = 6'b100_001;
    localparam logic [5:0] L_EW_Y    = 6'b100_010;
    localparam logic [5:0] L_CONFL   = 6'b001_001;
    localparam logic [5:0] L_DARK    = 6'b000_000;
    localparam logic [5:0] L_BADENC  = 6'b110_100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       fault_clear = 1'b0;
    logic       rn = 1'b0, yn = 1'b0, gn = 1'b0, re = 1'b0, ye = 1'b0, ge = 1'b0;
    logic [2:0] phase;
    logic [7:0] dwell;
    logic [7:0] cycle_count;
    logic       fault;
    logic [2:0] fault_code;

    int checks_total  = 0;
    int checks_passed = 0;

    traffic_light_monitor #(
        .MIN_GREEN(4),
        .MAX_PHASE(20),
        .CNT_W    (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fault_clear(fault_clear),
        .rn         (rn),
        .yn         (yn),
        .gn         (gn),
        .re         (re),
        .ye         (ye),
        .ge         (ge),
        .phase      (phase),
        .dwell      (dwell),
        .cycle_count(cycle_count),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Present one lamp sample across a clock edge, then report the outputs.
    task automatic step(input logic [5:0] l);
        {rn, yn, gn, re, ye, ge} = l;
        @(posedge clock);
        #1;
        $display("t=%0t lamps=%b clr=%b rst=%b -> phase=%0d dwell=%0d cycles=%0d fault=%0b code=%0d",
                 $time, l, fault_clear, reset, phase, dwell, cycle_count, fault, fault_code);
    endtask

    // Hold one legal phase for n samples, checking the entry and final dwell.
    task automatic run_phase(input string name, input logic [5:0] l, input int n, input logic [2:0] exp_ph);
        for (int i = 0; i < n; i++) begin
            step(l);
            if (i == 0) begin
                check_value($sformatf("%s_phase", name), 32'(phase), 32'(exp_ph));
                check_value($sformatf("%s_dwell_entry", name), 32'(dwell), 32'd1);
            end
        end
        check_value($sformatf("%s_dwell_final", name), 32'(dwell), 32'(n));
    endtask

    // One-edge fault_clear pulse with the given lamps present.
    task automatic pulse_clear(input logic [5:0] l);
        fault_clear = 1'b1;
        step(l);
        fault_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(L_DARK);
        step(L_DARK);
        reset = 1'b0;
        check_value("rst_phase", 32'(phase), 32'd0);
        check_value("rst_dwell", 32'(dwell), 32'd0);
        check_value("rst_cycles", 32'(cycle_count), 32'd0);
        check_value("rst_fault", 32'(fault), 32'd0);
        check_value("rst_code", 32'(fault_code), 32'd0);

        // Full legal cycle
        run_phase("seq_nsg", L_NS_G, 5, 3'd1);
        run_phase("seq_nsy", L_NS_Y, 2, 3'd2);
        run_phase("seq_ar1", L_ALL_RED, 2, 3'd3);
        run_phase("seq_ewg", L_EW_G, 5, 3'd4);
        run_phase("seq_ewy", L_EW_Y, 2, 3'd5);
        run_phase("seq_ar2", L_ALL_RED, 2, 3'd3);
        run_phase("seq_nsg2", L_NS_G, 1, 3'd1);
        check_value("seq_cycles", 32'(cycle_count), 32'd1);
        check_value("seq_fault", 32'(fault), 32'd0);
        check_value("seq_code", 32'(fault_code), 32'd0);

        // Conflict in RUN
        step(L_CONFL);
        check_value("confl_fault", 32'(fault), 32'd1);
        check_value("confl_code", 32'(fault_code), 32'd1);
        check_value("confl_phase", 32'(phase), 32'd7);
        check_value("confl_dwell", 32'(dwell), 32'd1);
        step(L_ALL_RED);
        check_value("post_confl_phase", 32'(phase), 32'd3);
        step(L_NS_G);
        check_value("post_confl_phase2", 32'(phase), 32'd1);
        check_value("post_confl_code", 32'(fault_code), 32'd1);
        check_value("post_confl_fault", 32'(fault), 32'd1);
        check_value("post_confl_cycles", 32'(cycle_count), 32'd1);

        // Clear with a legal pattern present: sample ignored, count kept
        pulse_clear(L_NS_G);
        check_value("clr1_fault", 32'(fault), 32'd0);
        check_value("clr1_code", 32'(fault_code), 32'd0);
        check_value("clr1_phase", 32'(phase), 32'd0);
        check_value("clr1_dwell", 32'(dwell), 32'd0);
        check_value("clr1_cycles", 32'(cycle_count), 32'd1);

        // Same-direction green repeated -> SEQUENCE
        run_phase("sq_nsg", L_NS_G, 5, 3'd1);
        run_phase("sq_nsy", L_NS_Y, 1, 3'd2);
        run_phase("sq_ar", L_ALL_RED, 1, 3'd3);
        check_value("sq_nofault_yet", 32'(fault), 32'd0);
        step(L_NS_G);
        check_value("sq_fault", 32'(fault), 32'd1);
        check_value("sq_code", 32'(fault_code), 32'd3);
        check_value("sq_cycles", 32'(cycle_count), 32'd1);

        // Clear with an illegal pattern present: no fault raised
        pulse_clear(L_DARK);
        check_value("clr2_fault", 32'(fault), 32'd0);
        check_value("clr2_phase", 32'(phase), 32'd0);
        check_value("clr2_code", 32'(fault_code), 32'd0);
        run_phase("sync_ewy", L_EW_Y, 1, 3'd5);
        check_value("sync_ewy_fault", 32'(fault), 32'd0);

        // No green seen since sync: ALL_RED->NS_G is legal and counts a cycle
        run_phase("sync_ar", L_ALL_RED, 1, 3'd3);
        run_phase("short_nsg", L_NS_G, 3, 3'd1);
        check_value("sync_cycles", 32'(cycle_count), 32'd2);
        check_value("short_nofault_yet", 32'(fault), 32'd0);

        // Green held 3 samples -> SHORT_GREEN
        step(L_NS_Y);
        check_value("short_fault", 32'(fault), 32'd1);
        check_value("short_code", 32'(fault_code), 32'd4);
        check_value("short_phase", 32'(phase), 32'd2);

        // Green held exactly MIN_GREEN samples -> no fault
        pulse_clear(L_NS_Y);
        run_phase("min_nsg", L_NS_G, 4, 3'd1);
        step(L_NS_Y);
        check_value("min_fault", 32'(fault), 32'd0);
        check_value("min_phase", 32'(phase), 32'd2);

        // Reset together with fault_clear: everything to zero
        reset = 1'b1;
        fault_clear = 1'b1;
        step(L_NS_Y);
        reset = 1'b0;
        fault_clear = 1'b0;
        check_value("rstclr_phase", 32'(phase), 32'd0);
        check_value("rstclr_dwell", 32'(dwell), 32'd0);
        check_value("rstclr_cycles", 32'(cycle_count), 32'd0);
        check_value("rstclr_fault", 32'(fault), 32'd0);
        check_value("rstclr_code", 32'(fault_code), 32'd0);

        // ALL_RED held MAX_PHASE samples is fine, one more is STUCK
        run_phase("stuck_ar", L_ALL_RED, 20, 3'd3);
        check_value("stuck_nofault_20", 32'(fault), 32'd0);
        step(L_ALL_RED);
        check_value("stuck_fault", 32'(fault), 32'd1);
        check_value("stuck_code", 32'(fault_code), 32'd5);
        check_value("stuck_dwell", 32'(dwell), 32'd21);

        // Non-one-hot group in SYNC -> ENCODING
        pulse_clear(L_ALL_RED);
        step(L_BADENC);
        check_value("enc_fault", 32'(fault), 32'd1);
        check_value("enc_code", 32'(fault_code), 32'd2);
        check_value("enc_phase", 32'(phase), 32'd7);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
